// File: rtl/mmio_isqrt_core.sv
// MMIO slot core (slot 13): iterative restoring integer square root, one root bit per clock.
// Optional cycle counter on register 5 is built when ISQRT_CYCLE_CNT_EN is defined.
module mmio_isqrt_core #(
    parameter int unsigned W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    output logic [31:0] rd_data,
    input  logic [31:0] wr_data
);

    localparam int unsigned H     = W / 2;
    localparam int unsigned IterW = $clog2(H + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDoneWb} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       operand_q, operand_d;
    logic [W-1:0]       x_work_q, x_work_d;
    logic [H+1:0]       rem_w_q, rem_w_d;
    logic [H-1:0]       root_w_q, root_w_d;
    logic [IterW-1:0]   iter_q, iter_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [H-1:0]       root_q, root_d;
    logic [H:0]         rem_q, rem_d;
`ifdef ISQRT_CYCLE_CNT_EN
    logic [31:0]        cycles_q, cycles_d;
`endif

    logic               wr_en;
    logic               start_cmd;
    logic               clear_cmd;
    logic [H+1:0]       rem_shift;
    logic [H+1:0]       trial;
    logic               fits;
    logic               unused_bits;

    assign wr_en     = cs & write;
    assign start_cmd = wr_en && (addr == 5'd1) && wr_data[0];
    assign clear_cmd = wr_en && (addr == 5'd1) && wr_data[1];

    // Top two bits of rem_w are always zero before the shift, so dropping them is lossless.
    assign rem_shift = {rem_w_q[H-1:0], x_work_q[W-1:W-2]};
    assign trial     = {root_w_q, 2'b01};
    assign fits      = (rem_shift >= trial);

    assign unused_bits = ^{read, wr_data, rem_w_q[H+1]};

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        x_work_d  = x_work_q;
        rem_w_d   = rem_w_q;
        root_w_d  = root_w_q;
        iter_d    = iter_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        root_d    = root_q;
        rem_d     = rem_q;
`ifdef ISQRT_CYCLE_CNT_EN
        cycles_d  = busy_q ? cycles_q + 32'd1 : cycles_q;
`endif

        if (wr_en && (addr == 5'd0)) begin
            operand_d = wr_data[W-1:0];
        end
        if (clear_cmd) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (start_cmd && busy_q) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_cmd) begin
                    x_work_d = operand_q;
                    rem_w_d  = '0;
                    root_w_d = '0;
                    iter_d   = IterW'(H);
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = StRun;
`ifdef ISQRT_CYCLE_CNT_EN
                    cycles_d = 32'd0;
`endif
                end
            end
            StRun: begin
                x_work_d = x_work_q << 2;
                if (fits) begin
                    rem_w_d  = rem_shift - trial;
                    root_w_d = {root_w_q[H-2:0], 1'b1};
                end else begin
                    rem_w_d  = rem_shift;
                    root_w_d = {root_w_q[H-2:0], 1'b0};
                end
                iter_d = iter_q - 1'b1;
                if (iter_q == IterW'(1)) begin
                    state_d = StDoneWb;
                end
            end
            StDoneWb: begin
                root_d  = root_w_q;
                rem_d   = rem_w_q[H:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            operand_q <= '0;
            x_work_q  <= '0;
            rem_w_q   <= '0;
            root_w_q  <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            root_q    <= '0;
            rem_q     <= '0;
`ifdef ISQRT_CYCLE_CNT_EN
            cycles_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            x_work_q  <= x_work_d;
            rem_w_q   <= rem_w_d;
            root_w_q  <= root_w_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
`ifdef ISQRT_CYCLE_CNT_EN
            cycles_q  <= cycles_d;
`endif
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr)
            5'd0: rd_data = 32'(operand_q);
            5'd2: rd_data = {29'd0, err_q, done_q, busy_q};
            5'd3: rd_data = 32'(root_q);
            5'd4: rd_data = 32'(rem_q);
`ifdef ISQRT_CYCLE_CNT_EN
            5'd5: rd_data = cycles_q;
`endif
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mmio_isqrt_core.sv
// Self-checking bench for mmio_isqrt_core (W=32): scoreboard of model results, polled via MMIO.
module tb_mmio_isqrt_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] rd_data;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] root;
        logic [31:0] rem;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_root;

`ifdef ISQRT_CYCLE_CNT_EN
    localparam logic [31:0] ExpCycles = 32'd17;
`else
    localparam logic [31:0] ExpCycles = 32'd0;
`endif

    always #5 clk = ~clk;

    mmio_isqrt_core #(.W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .rd_data (rd_data),
        .wr_data (wr_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Independent model: greedy bit-by-bit search on the square.
    function automatic exp_t isqrt_model(input logic [31:0] x);
        exp_t   e;
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        e.root = 32'(r);
        e.rem  = 32'(longint'(x) - r * r);
        return e;
    endfunction

    // All bus tasks start and end at posedge+1.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0; wr_data = 32'd0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(output int busy_cycles);
        logic [31:0] st;
        busy_cycles = 0;
        read_reg(5'd2, st);
        while (st[0] && busy_cycles < 200) begin
            busy_cycles++;
            step(1);
            read_reg(5'd2, st);
        end
        if (busy_cycles >= 200) check_eq("timeout", 32'd1, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_status);
        exp_t        e;
        logic [31:0] v;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            read_reg(5'd3, v); check_eq({tag, "_root"}, v, e.root);
            read_reg(5'd4, v); check_eq({tag, "_rem"}, v, e.rem);
            read_reg(5'd2, v); check_eq({tag, "_status"}, v, exp_status);
            last_root = e.root;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x);
        int          n;
        logic [31:0] v;
        sb.push_back(isqrt_model(x));
        write_reg(5'd0, x);
        write_reg(5'd1, 32'd1);
        wait_done(n);
        check_eq({tag, "_busy_cycles"}, 32'(n), 32'd17);
        check_result(tag, 32'd2);
        read_reg(5'd5, v); check_eq({tag, "_cycles"}, v, ExpCycles);
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] v;
        for (int a = 0; a < 6; a++) begin
            read_reg(5'(a), v);
            check_eq($sformatf("%s_reg%0d", tag, a), v, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        check_all_zero("reset");

        run_op("op17", 32'd17);
        run_op("op0", 32'd0);
        run_op("op1", 32'd1);
        run_op("op1e6", 32'd1000000);
        run_op("opmax", 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            run_op($sformatf("rnd%0d", i), $urandom);
        end

        // Start while busy sets err; running op keeps its latched operand.
        sb.push_back(isqrt_model(32'h51));
        write_reg(5'd0, 32'h51);
        write_reg(5'd1, 32'd1);
        step(2);
        read_reg(5'd3, v); check_eq("err_root_held", v, last_root);
        write_reg(5'd0, 32'd4);
        write_reg(5'd1, 32'd1);
        read_reg(5'd2, v); check_eq("err_status_mid", v, 32'd5);
        wait_done(n);
        check_result("err", 32'd6);
        read_reg(5'd0, v); check_eq("err_operand", v, 32'd4);
        write_reg(5'd1, 32'd2);
        read_reg(5'd2, v); check_eq("clear_status", v, 32'd0);

        // Reset mid-operation aborts it.
        write_reg(5'd0, 32'h1234_5678);
        write_reg(5'd1, 32'd1);
        step(5);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_all_zero("abort");
        step(3);
        read_reg(5'd2, v); check_eq("abort_status_later", v, 32'd0);
        run_op("after_abort", 32'h1234_5678);

        // Simultaneous start and clear in idle: start accepted, err cleared.
        write_reg(5'd0, 32'd144);
        write_reg(5'd1, 32'd1);
        write_reg(5'd1, 32'd1);
        sb.push_back(isqrt_model(32'd144));
        wait_done(n);
        check_result("pre_both", 32'd6);
        write_reg(5'd1, 32'd3);
        sb.push_back(isqrt_model(32'd144));
        read_reg(5'd2, v); check_eq("both_status", v, 32'd1);
        wait_done(n);
        check_result("both", 32'd2);

        // Unmapped and read-only addresses.
        read_reg(5'd6, v);  check_eq("addr6", v, 32'd0);
        read_reg(5'd31, v); check_eq("addr31", v, 32'd0);
        write_reg(5'd3, 32'hDEAD);
        read_reg(5'd3, v);  check_eq("ro_root", v, last_root);
        write_reg(5'd2, 32'hFFFF_FFFF);
        read_reg(5'd2, v);  check_eq("ro_status", v, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
